// File: rtl/serial_frame_receiver.sv
// Framed MSB-first serial receiver: start bit, width data bits, stop bit,
// delivered through a one-entry valid/ready buffer with sticky error flags.
module serial_frame_receiver #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             ready,
  input  logic             clear_err,
  output logic [width-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [1:0]       fsm_state
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [width-1:0] shreg;

  // Handshake: a word transfers on any edge where valid and ready are both 1;
  // the buffer may reload on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (valid && ready) valid <= 1'b0;
      if (clear_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (sin_en) begin
        unique case (state)
          IDLE: begin
            if (!sin) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= {shreg[width-2:0], sin};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(width - 1)) state <= STOP;
          end
          STOP: begin
            // A 0 here is a framing error, never a new start bit.
            state <= IDLE;
            if (sin) begin
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: width=8 instance for most cases,
// width=4 instance for back-to-back frames.
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin8, en8, rdy8, clr8;
  logic [7:0] data8;
  logic       valid8, busy8, ferr8, ovr8;
  logic [1:0] st8;
  logic       sin4, en4, rdy4, clr4;
  logic [3:0] data4;
  logic       valid4, busy4, ferr4, ovr4;
  logic [1:0] st4;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  serial_frame_receiver #(.width(8)) dut8 (
    .clk(clk), .reset(rst), .sin(sin8), .sin_en(en8), .ready(rdy8),
    .clear_err(clr8), .data(data8), .valid(valid8), .busy(busy8),
    .frame_err(ferr8), .overrun(ovr8), .fsm_state(st8)
  );

  serial_frame_receiver #(.width(4)) dut4 (
    .clk(clk), .reset(rst), .sin(sin4), .sin_en(en4), .ready(rdy4),
    .clear_err(clr4), .data(data4), .valid(valid4), .busy(busy4),
    .frame_err(ferr4), .overrun(ovr4), .fsm_state(st4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample 1 time unit after the edge.
  task automatic tick8(input logic en, input logic s);
    en8  = en;
    sin8 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic tick4(input logic en, input logic s);
    en4  = en;
    sin4 = s;
    @(posedge clk);
    #1;
  endtask

  // Start bit + 8 data bits MSB-first, all strobed back to back (stop not sent).
  task automatic send_body8(input logic [7:0] w);
    tick8(1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) tick8(1'b1, w[i]);
  endtask

  logic [3:0] exp_q[$];
  int         pulse_cyc[$];
  logic [3:0] seq4;

  initial begin
    rst = 1'b1; sin8 = 1'b1; en8 = 1'b0; rdy8 = 1'b0; clr8 = 1'b0;
    sin4 = 1'b1; en4 = 1'b0; rdy4 = 1'b1; clr4 = 1'b0;
    tick8(1'b0, 1'b1);
    tick8(1'b0, 1'b1);
    check("rst_data", data8, 0);
    check("rst_valid", valid8, 0);
    check("rst_busy", busy8, 0);
    check("rst_ferr", ferr8, 0);
    check("rst_ovr", ovr8, 0);
    check("rst_state", st8, 0);
    check("rst4_valid", valid4, 0);
    rst = 1'b0;

    // Basic word A5: line 0,1,0,1,0,0,1,0,1,1; busy checked every cycle.
    tick8(1'b1, 1'b1);
    check("idle_ones_ignored", busy8, 0);
    begin
      logic [9:0] line;
      line = 10'b0101001011;
      for (int i = 9; i >= 0; i--) begin
        tick8(1'b1, line[i]);
        check($sformatf("basic_busy_%0d", 9 - i), busy8, (i != 0));
        if (i == 1) check("basic_valid_early", valid8, 0);
      end
    end
    check("basic_data", data8, 8'hA5);
    check("basic_valid", valid8, 1);
    check("basic_ferr", ferr8, 0);
    check("basic_ovr", ovr8, 0);
    tick8(1'b0, 1'b1);
    check("hold_unaccepted", data8, 8'hA5);
    check("hold_valid", valid8, 1);
    rdy8 = 1'b1;
    tick8(1'b0, 1'b1);
    check("accept_valid_fall", valid8, 0);
    rdy8 = 1'b0;

    // Gapped strobes: sin forced 0 between strobes.
    begin
      logic [9:0] line;
      line = 10'b0101001011;
      for (int i = 9; i >= 0; i--) begin
        tick8(1'b1, line[i]);
        tick8(1'b0, 1'b0);
        tick8(1'b0, 1'b0);
      end
    end
    check("gap_data", data8, 8'hA5);
    check("gap_valid", valid8, 1);
    check("gap_no_spurious_start", busy8, 0);
    rdy8 = 1'b1;
    tick8(1'b0, 1'b1);
    rdy8 = 1'b0;
    check("gap_accept", valid8, 0);

    // Framing error on 3C.
    send_body8(8'h3C);
    check("ferr_busy_stop", busy8, 1);
    tick8(1'b1, 1'b0);
    check("ferr_flag", ferr8, 1);
    check("ferr_valid", valid8, 0);
    check("ferr_state_idle", st8, 0);
    tick8(1'b1, 1'b1);
    check("ferr_sticky", ferr8, 1);
    clr8 = 1'b1;
    tick8(1'b0, 1'b1);
    clr8 = 1'b0;
    check("ferr_cleared", ferr8, 0);

    // Error coinciding with clear_err must leave the flag set.
    send_body8(8'h55);
    clr8 = 1'b1;
    tick8(1'b1, 1'b0);
    clr8 = 1'b0;
    check("ferr_beats_clear", ferr8, 1);
    clr8 = 1'b1;
    tick8(1'b0, 1'b1);
    clr8 = 1'b0;

    // Overrun: 11 then 22 with ready low.
    send_body8(8'h11);
    tick8(1'b1, 1'b1);
    check("ovr_first_data", data8, 8'h11);
    check("ovr_first_valid", valid8, 1);
    send_body8(8'h22);
    tick8(1'b1, 1'b1);
    check("ovr_data_held", data8, 8'h11);
    check("ovr_valid_held", valid8, 1);
    check("ovr_flag", ovr8, 1);
    check("ovr_no_ferr", ferr8, 0);
    rdy8 = 1'b1;
    tick8(1'b1, 1'b1);
    rdy8 = 1'b0;
    check("ovr_drain", valid8, 0);
    check("ovr_sticky", ovr8, 1);
    clr8 = 1'b1;
    tick8(1'b0, 1'b1);
    clr8 = 1'b0;
    check("ovr_cleared", ovr8, 0);

    // Variant: ready rises in the stop cycle of 22, so it loads.
    send_body8(8'h11);
    tick8(1'b1, 1'b1);
    send_body8(8'h22);
    rdy8 = 1'b1;
    tick8(1'b1, 1'b1);
    rdy8 = 1'b0;
    check("drain_load_data", data8, 8'h22);
    check("drain_load_valid", valid8, 1);
    check("drain_load_ovr", ovr8, 0);

    // Reset mid-frame of F0 with 22 still buffered.
    tick8(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick8(1'b1, 1'b1);
    check("pre_rst_busy", busy8, 1);
    rst = 1'b1;
    tick8(1'b1, 1'b1);
    rst = 1'b0;
    check("mid_rst_data", data8, 0);
    check("mid_rst_valid", valid8, 0);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_ferr", ferr8, 0);
    check("mid_rst_ovr", ovr8, 0);
    send_body8(8'h0F);
    tick8(1'b1, 1'b1);
    check("post_rst_data", data8, 8'h0F);
    check("post_rst_valid", valid8, 1);
    tick8(1'b0, 1'b1);

    // Back-to-back width=4 frames 9 and 6, ready held high.
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h6);
    for (int c = 0; c < 16; c++) begin
      logic s;
      seq4 = 4'h9;
      if (c == 0 || c == 6) s = 1'b0;
      else if (c >= 1 && c <= 4) s = seq4[4 - c];
      else if (c >= 7 && c <= 10) begin
        seq4 = 4'h6;
        s = seq4[10 - c];
      end else s = 1'b1;
      tick4(1'b1, s);
      if (valid4) begin
        pulse_cyc.push_back(c);
        if (exp_q.size() > 0) check("b2b_data", data4, exp_q.pop_front());
        else check("b2b_extra_pulse", 1, 0);
      end
    end
    check("b2b_pulses", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) check("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], 6);
    check("b2b_ferr", ferr4, 0);
    check("b2b_ovr", ovr4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
